// File: rtl/lifo_arbiter_if.sv
// Purpose: bundles the client command/response bus, flush request and LIFO-side strobes of lifo_arbiter.
// Latency: none, wiring only.
// Backpressure: cmd_ready_o is the only flow-control signal; responses cannot be stalled.
interface lifo_arbiter_if #(
  parameter int CLIENTS = 2,
  parameter int DWIDTH  = 16
);
  logic [CLIENTS-1:0]        cmd_valid_i;
  logic [CLIENTS-1:0]        cmd_op_i;
  logic [CLIENTS*DWIDTH-1:0] cmd_data_i;
  logic [CLIENTS-1:0]        cmd_ready_o;
  logic [CLIENTS-1:0]        rsp_valid_o;
  logic                      rsp_err_o;
  logic [DWIDTH-1:0]         rsp_data_o;
  logic                      flush_i;
  logic                      lifo_srst_o;
  logic                      lifo_wrreq_o;
  logic                      lifo_rdreq_o;
  logic [DWIDTH-1:0]         lifo_data_o;
  logic [DWIDTH-1:0]         lifo_q_i;
  logic                      lifo_empty_i;
  logic                      lifo_full_i;

  // Arbiter view
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_data_i, flush_i, lifo_q_i, lifo_empty_i, lifo_full_i,
    output cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
           lifo_srst_o, lifo_wrreq_o, lifo_rdreq_o, lifo_data_o
  );

  // Environment view (clients plus the attached LIFO)
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_data_i, flush_i, lifo_q_i, lifo_empty_i, lifo_full_i,
    input  cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
           lifo_srst_o, lifo_wrreq_o, lifo_rdreq_o, lifo_data_o
  );
endinterface

// File: rtl/lifo_arbiter.sv
// Purpose: round-robin arbiter sharing one LIFO among CLIENTS requesters, one operation in flight.
// Latency: push/error response 2 cycles after accept, pop response 2+RD_LATENCY cycles after accept.
// Backpressure: cmd_ready_o only in IDLE and only to the winner; flush_i pre-empts all clients.
module lifo_arbiter #(
  parameter int CLIENTS    = 2,
  parameter int DWIDTH     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  lifo_arbiter_if.slave bus
);

  localparam int IW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic                op_q, op_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          wcnt_q, wcnt_d;

  logic                found;
  logic [IW-1:0]       win;
  int                  idx;
  logic [CLIENTS-1:0]  grant;

  logic [CLIENTS-1:0]  rsp_valid;
  logic                rsp_err;
  logic [DWIDTH-1:0]   rsp_data;
  logic                srst, wrreq, rdreq;
  logic [DWIDTH-1:0]   lifo_data;

  // Round-robin search starting at the priority pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < CLIENTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= CLIENTS) idx = idx - CLIENTS;
      if (!found && bus.cmd_valid_i[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    grant     = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    srst      = 1'b0;
    wrreq     = 1'b0;
    rdreq     = 1'b0;
    lifo_data = '0;
    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
        end else if (found) begin
          grant[win] = 1'b1;
          owner_d    = win;
          op_d       = bus.cmd_op_i[win];
          data_d     = bus.cmd_data_i[int'(win)*DWIDTH +: DWIDTH];
          ptr_d      = (int'(win) == CLIENTS - 1) ? '0 : win + 1'b1;
          err_d      = 1'b0;
          rdata_d    = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rdata_d = '0;
        if (!op_q) begin
          // Push: write only when there is room, otherwise report an error
          if (!bus.lifo_full_i) begin
            wrreq     = 1'b1;
            lifo_data = data_q;
            err_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end else if (!bus.lifo_empty_i) begin
          rdreq   = 1'b1;
          wcnt_d  = 2'(RD_LATENCY - 1);
          state_d = WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        // Count down the LIFO read latency; q is valid on the last WAIT cycle
        if (wcnt_q == 2'd0) begin
          rdata_d = bus.lifo_q_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_err            = err_q;
        rsp_data           = rdata_q;
        state_d            = IDLE;
      end
      FLUSH: begin
        srst    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-command registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Grant is combinational from the inputs, so it is gated while reset is asserted
  assign bus.cmd_ready_o  = grant & {CLIENTS{arstn_i}};
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_err_o    = rsp_err;
  assign bus.rsp_data_o   = rsp_data;
  assign bus.lifo_srst_o  = srst;
  assign bus.lifo_wrreq_o = wrreq;
  assign bus.lifo_rdreq_o = rdreq;
  assign bus.lifo_data_o  = lifo_data;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Purpose: self-checking bench for lifo_arbiter with a behavioural LIFO and a transaction-level reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_lifo_arbiter;
  localparam int NC    = 2;
  localparam int DW    = 16;
  localparam int RL    = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  lifo_arbiter_if #(.CLIENTS(NC), .DWIDTH(DW)) bus ();

  lifo_arbiter #(.CLIENTS(NC), .DWIDTH(DW), .RD_LATENCY(RL)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Attached LIFO: depth 4, q registered one cycle after rdreq
  logic [DW-1:0] mem [DEPTH];
  int            cnt = 0;
  logic [DW-1:0] q_r = '0;
  always @(posedge clk) begin
    if (bus.lifo_srst_o) cnt <= 0;
    else if (bus.lifo_wrreq_o && cnt < DEPTH) begin
      mem[cnt] <= bus.lifo_data_o;
      cnt      <= cnt + 1;
    end else if (bus.lifo_rdreq_o && cnt > 0) begin
      q_r <= mem[cnt-1];
      cnt <= cnt - 1;
    end
  end
  assign bus.lifo_q_i     = q_r;
  assign bus.lifo_empty_i = (cnt == 0);
  assign bus.lifo_full_i  = (cnt == DEPTH);

  // Reference: schedule of expected events per accepted command
  int idle_at = 0, wr_at = -1, rd_at = -1, srst_at = -1, rsp_at = -1, rsp_cl = 0;
  int ptr_m = 0, m_idx = 0, m_k = 0;
  bit rsp_e = 1'b0, m_got = 1'b0;
  logic [DW-1:0] rsp_d = '0, wdat = '0, m_d = '0;
  logic [DW-1:0] stk [$];
  logic [NC-1:0] exp_rdy, exp_rv;

  initial forever begin
    @(negedge clk);
    if (run) begin
      if (!arstn) begin
        chk("reset_outputs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o,
            bus.lifo_srst_o, bus.lifo_wrreq_o, bus.lifo_rdreq_o, bus.lifo_data_o}, 64'd0);
        idle_at = 0; wr_at = -1; rd_at = -1; srst_at = -1; rsp_at = -1; ptr_m = 0;
      end else begin
        exp_rdy = '0;
        if (cyc >= idle_at) begin
          if (bus.flush_i) begin
            srst_at = cyc + 1;
            idle_at = cyc + 2;
            stk.delete();
          end else if (|bus.cmd_valid_i) begin
            m_got = 1'b0; m_k = 0;
            for (int i = 0; i < NC; i++) begin
              m_idx = (ptr_m + i) % NC;
              if (!m_got && bus.cmd_valid_i[m_idx]) begin m_got = 1'b1; m_k = m_idx; end
            end
            exp_rdy[m_k] = 1'b1;
            ptr_m  = (m_k + 1) % NC;
            rsp_cl = m_k;
            m_d    = bus.cmd_data_i[m_k*DW +: DW];
            rsp_d  = '0;
            rsp_e  = 1'b0;
            rsp_at = cyc + 2;
            if (!bus.cmd_op_i[m_k]) begin
              if (stk.size() < DEPTH) begin wr_at = cyc + 1; wdat = m_d; stk.push_back(m_d); end
              else rsp_e = 1'b1;
            end else begin
              if (stk.size() > 0) begin rd_at = cyc + 1; rsp_d = stk.pop_back(); rsp_at = cyc + 2 + RL; end
              else rsp_e = 1'b1;
            end
            idle_at = rsp_at + 1;
          end
        end
        exp_rv = '0;
        if (cyc == rsp_at) exp_rv[rsp_cl] = 1'b1;
        chk("grant", bus.cmd_ready_o, exp_rdy);
        chk("wrreq", bus.lifo_wrreq_o, cyc == wr_at);
        chk("wdata", bus.lifo_data_o, (cyc == wr_at) ? wdat : '0);
        chk("rdreq", bus.lifo_rdreq_o, cyc == rd_at);
        chk("srst", bus.lifo_srst_o, cyc == srst_at);
        chk("rsp_valid", bus.rsp_valid_o, exp_rv);
        chk("wr_rd_excl", bus.lifo_wrreq_o & bus.lifo_rdreq_o, 0);
        if (cyc == rsp_at) begin
          chk("rsp_err", bus.rsp_err_o, rsp_e);
          chk("rsp_data", bus.rsp_data_o, rsp_d);
        end
      end
    end
  end

  task automatic do_cmd(input int k, input bit op, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output bit er, output int lat);
    int t0;
    bit got;
    rd = '0; er = 1'b0; lat = -1; t0 = 0; got = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid_i[k] = 1'b1;
    bus.cmd_op_i[k]    = op;
    bus.cmd_data_i[k*DW +: DW] = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.cmd_ready_o[k]) begin got = 1'b1; t0 = cyc; break; end
    end
    chk("grant_seen", got, 1);
    @(posedge clk); #1;
    bus.cmd_valid_i[k] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rsp_valid_o[k]) begin
        got = 1'b1; rd = bus.rsp_data_o; er = bus.rsp_err_o; lat = cyc - t0; break;
      end
    end
    chk("rsp_seen", got, 1);
  endtask

  task automatic do_flush();
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(posedge clk);
  endtask

  typedef struct {
    bit            rst_n;
    logic [NC-1:0] v;
    bit            f;
    logic [NC-1:0] exp_rdy;
  } vec_t;
  vec_t tbl [8];

  logic [DW-1:0] rd;
  bit            er;
  int            lat;
  bit            got;
  logic [NC-1:0] exp_g;

  initial begin
    tbl[0] = '{1'b1, 2'b00, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 2'b01, 1'b0, 2'b01};
    tbl[2] = '{1'b1, 2'b10, 1'b0, 2'b10};
    tbl[3] = '{1'b1, 2'b11, 1'b0, 2'b01};
    tbl[4] = '{1'b1, 2'b11, 1'b1, 2'b00};
    tbl[5] = '{1'b1, 2'b10, 1'b1, 2'b00};
    tbl[6] = '{1'b0, 2'b11, 1'b0, 2'b00};
    tbl[7] = '{1'b0, 2'b01, 1'b0, 2'b00};

    bus.cmd_valid_i = '0;
    bus.cmd_op_i    = '0;
    bus.cmd_data_i  = '0;
    bus.flush_i     = 1'b0;
    repeat (2) @(posedge clk);

    // Combinational grant from IDLE with pointer at reset value
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      arstn = 1'b0;
      #1;
      arstn = tbl[i].rst_n;
      bus.cmd_valid_i = tbl[i].v;
      bus.flush_i     = tbl[i].f;
      bus.cmd_op_i    = '0;
      #1;
      chk("tbl_grant", bus.cmd_ready_o, tbl[i].exp_rdy);
    end
    arstn = 1'b0;
    bus.cmd_valid_i = '0;
    bus.flush_i     = 1'b0;
    run = 1'b1;
    @(posedge clk); #1 arstn = 1'b1;

    // Push then pop through the LIFO
    do_cmd(0, 1'b0, 16'h1234, rd, er, lat);
    chk("push_err", er, 0);
    chk("push_lat", lat, 2);
    do_cmd(1, 1'b1, 16'h0000, rd, er, lat);
    chk("pop_data", rd, 16'h1234);
    chk("pop_err", er, 0);
    chk("pop_lat", lat, 2 + RL);

    // Pop on empty
    do_cmd(0, 1'b1, 16'h0000, rd, er, lat);
    chk("pop_empty_err", er, 1);
    chk("pop_empty_data", rd, 0);
    chk("pop_empty_lat", lat, 2);

    // Fill to full, then one push too many
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(i % NC, 1'b0, 16'(16'hA000 + i), rd, er, lat);
      chk("fill_err", er, 0);
    end
    do_cmd(1, 1'b0, 16'hDEAD, rd, er, lat);
    chk("push_full_err", er, 1);
    chk("push_full_lat", lat, 2);
    do_cmd(0, 1'b1, 16'h0000, rd, er, lat);
    chk("pop_top", rd, 16'hA003);

    // Flush and a command together: flush wins, command follows
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    bus.cmd_valid_i = 2'b01; bus.cmd_op_i = 2'b00; bus.cmd_data_i[0 +: DW] = 16'h5555;
    @(negedge clk);
    chk("flush_no_grant", bus.cmd_ready_o, 2'b00);
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_srst", bus.lifo_srst_o, 1);
    chk("flush_state_no_grant", bus.cmd_ready_o, 2'b00);
    @(negedge clk);
    chk("after_flush_grant", bus.cmd_ready_o, 2'b01);
    @(posedge clk); #1 bus.cmd_valid_i = '0;
    repeat (4) @(posedge clk);

    // Both clients pushing continuously from reset
    #1 arstn = 1'b0;
    @(posedge clk); #1;
    arstn = 1'b1;
    bus.cmd_valid_i = 2'b11; bus.cmd_op_i = 2'b00; bus.cmd_data_i = 32'h7777_8888;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_g = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_grant", bus.cmd_ready_o, exp_g);
    end
    @(posedge clk); #1 bus.cmd_valid_i = '0;
    repeat (3) @(posedge clk);

    // Reset during the WAIT phase of a pop
    do_flush();
    do_cmd(0, 1'b0, 16'hBEEF, rd, er, lat);
    @(posedge clk); #1;
    bus.cmd_valid_i = 2'b10; bus.cmd_op_i = 2'b10;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.cmd_ready_o[1]) begin got = 1'b1; break; end
    end
    chk("pop_grant_seen", got, 1);
    @(posedge clk); #1 bus.cmd_valid_i = '0;
    @(posedge clk); #1 arstn = 1'b0;
    #1;
    chk("abort_outputs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o,
        bus.lifo_srst_o, bus.lifo_wrreq_o, bus.lifo_rdreq_o, bus.lifo_data_o}, 64'd0);
    @(posedge clk); #1;
    arstn = 1'b1;
    bus.cmd_valid_i = 2'b11; bus.cmd_op_i = 2'b00;
    @(negedge clk);
    chk("post_reset_grant", bus.cmd_ready_o, 2'b01);
    @(posedge clk); #1 bus.cmd_valid_i = '0;
    repeat (3) @(posedge clk);

    // Random traffic against the reference
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      bus.cmd_valid_i = NC'($urandom);
      bus.cmd_op_i    = NC'($urandom);
      bus.cmd_data_i  = (NC*DW)'($urandom);
      bus.flush_i     = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    bus.cmd_valid_i = '0;
    bus.flush_i     = 1'b0;
    repeat (10) @(posedge clk);
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
